alu_shifter: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/shifter_core.sv | 40 ++++
 rtl/alu_shifter.sv | 104 ++++++++++
 tb/tb_alu_shifter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the luftALU subunits: op codes and shift control types.
package alu_pkg;

    // 4-bit ALU op code shared by adder, logic and shift subunits.
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_OP_SRL = 4'b0001;
    localparam alu_op_t ALU_OP_SLL = 4'b0011;
    localparam alu_op_t ALU_OP_SRA = 4'b0111;

    // Direction control for the barrel shifter core.
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } shift_dir_t;

    // True when the op code names one of the shift operations.
    function automatic logic is_shift_op(input alu_op_t op);
        logic hit_s;
        case (op)
            ALU_OP_SRL: hit_s = 1'b1;
            ALU_OP_SLL: hit_s = 1'b1;
            ALU_OP_SRA: hit_s = 1'b1;
            default:    hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

endpackage

// File: rtl/shifter_core.sv
// Combinational log2(W)-stage barrel shifter. A single right-shifter serves
// both directions: left shifts are done as reverse -> shift right -> reverse.
module shifter_core
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  opd,
    input  logic [SW-1:0] shamt,
    input  shift_dir_t    dir,
    input  logic          arith,
    output logic [W-1:0]  result
);

    // stage_s[k] is the operand after the first k shift stages
    logic [W-1:0] stage_s [0:SW];
    logic         fill_s;

    // Sign fill only makes sense for right shifts; a left shift always fills 0.
    assign fill_s = (arith && (dir == DIR_RIGHT)) ? opd[W-1] : 1'b0;

    // Input bit-reversal for left shifts, pass-through for right shifts.
    for (genvar b = 0; b < W; b++) begin : g_rev_in
        assign stage_s[0][b] = (dir == DIR_LEFT) ? opd[W-1-b] : opd[b];
    end

    // Stage k shifts right by 2**k when shamt bit k is set.
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int STEP = 1 << k;
        assign stage_s[k+1] = shamt[k] ? {{STEP{fill_s}}, stage_s[k][W-1:STEP]}
                                       : stage_s[k];
    end

    // Output bit-reversal undoes the input reversal for left shifts.
    for (genvar b = 0; b < W; b++) begin : g_rev_out
        assign result[b] = (dir == DIR_LEFT) ? stage_s[SW][W-1-b] : stage_s[SW][b];
    end

endmodule

// File: rtl/alu_shifter.sv
// Registered shift unit of the luftALU: SLL / SRL / SRA of opd1 by opd2's low
// bits, one cycle latency, invalid op codes yield zero with op_invalid set.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int OPD_LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [3:0]            alu_op_select,
    output logic [OPD_LENGTH-1:0] shifter_result,
    output logic                  out_valid,
    output logic                  op_invalid
);

    localparam int SHAMT_W = $clog2(OPD_LENGTH);

    shift_dir_t              dir_s;
    logic                    arith_s;
    logic                    op_ok_s;
    logic [SHAMT_W-1:0]      shamt_s;
    logic [OPD_LENGTH-1:0]   core_result_s;
    logic [OPD_LENGTH-1:0]   next_result_s;
    logic                    unused_opd2_s;

    logic [OPD_LENGTH-1:0]   result_r;
    logic                    valid_r;
    logic                    invalid_r;

    // Only the low SHAMT_W bits select the amount; the rest are don't-care.
    assign shamt_s       = opd2[SHAMT_W-1:0];
    assign unused_opd2_s = ^opd2[OPD_LENGTH-1:SHAMT_W];

    // Op decode: map the shared ALU op code onto shifter direction and fill.
    always_comb begin
        dir_s   = DIR_RIGHT;
        arith_s = 1'b0;
        op_ok_s = is_shift_op(alu_op_t'(alu_op_select));
        case (alu_op_t'(alu_op_select))
            ALU_OP_SLL: begin
                dir_s   = DIR_LEFT;
                arith_s = 1'b0;
            end
            ALU_OP_SRL: begin
                dir_s   = DIR_RIGHT;
                arith_s = 1'b0;
            end
            ALU_OP_SRA: begin
                dir_s   = DIR_RIGHT;
                arith_s = 1'b1;
            end
            default: begin
                dir_s   = DIR_RIGHT;
                arith_s = 1'b0;
            end
        endcase
    end

    shifter_core #(
        .W  (OPD_LENGTH),
        .SW (SHAMT_W)
    ) u_core (
        .opd    (opd1),
        .shamt  (shamt_s),
        .dir    (dir_s),
        .arith  (arith_s),
        .result (core_result_s)
    );

    // Invalid op codes must not leak a shifted value onto the result bus.
    always_comb begin
        next_result_s = {OPD_LENGTH{1'b0}};
        if (op_ok_s) begin
            next_result_s = core_result_s;
        end else begin
            next_result_s = {OPD_LENGTH{1'b0}};
        end
    end

    // Output registers: async clear on reset, bubble writes zeros (no hold).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r  <= {OPD_LENGTH{1'b0}};
            valid_r   <= 1'b0;
            invalid_r <= 1'b0;
        end else if (in_valid) begin
            result_r  <= next_result_s;
            valid_r   <= 1'b1;
            invalid_r <= ~op_ok_s;
        end else begin
            result_r  <= {OPD_LENGTH{1'b0}};
            valid_r   <= 1'b0;
            invalid_r <= 1'b0;
        end
    end

    assign shifter_result = result_r;
    assign out_valid      = valid_r;
    assign op_invalid     = invalid_r;

endmodule

// File: tb/tb_alu_shifter.sv
// Self-checking bench for alu_shifter (OPD_LENGTH = 8): directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_alu_shifter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] opd1;
    logic [W-1:0] opd2;
    logic [3:0]   alu_op_select;
    logic [W-1:0] shifter_result;
    logic         out_valid;
    logic         op_invalid;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model outputs
    logic [W-1:0] m_res;
    logic         m_val;
    logic         m_inv;

    alu_shifter #(.OPD_LENGTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .opd1           (opd1),
        .opd2           (opd2),
        .alu_op_select  (alu_op_select),
        .shifter_result (shifter_result),
        .out_valid      (out_valid),
        .op_invalid     (op_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural rule: {invalid, result} for one operation.
    function automatic logic [W:0] model_op(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int sh;
        logic signed [W-1:0] sa;
        sh = int'(b) % W;
        sa = a;
        case (op)
            4'b0011: return {1'b0, a << sh};
            4'b0001: return {1'b0, a >> sh};
            4'b0111: return {1'b0, W'(sa >>> sh)};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    // Model state: one-cycle registered view of the rule above.
    always @(posedge clk or negedge rst_n) begin
        logic [W:0] r;
        if (!rst_n) begin
            m_res <= '0; m_val <= 1'b0; m_inv <= 1'b0;
        end else if (in_valid) begin
            r = model_op(alu_op_select, opd1, opd2);
            m_res <= r[W-1:0]; m_val <= 1'b1; m_inv <= r[W];
        end else begin
            m_res <= '0; m_val <= 1'b0; m_inv <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_result", 32'(shifter_result), 32'(m_res));
            check("model_valid",  32'(out_valid),      32'(m_val));
            check("model_inv",    32'(op_invalid),     32'(m_inv));
        end
    end

    // Apply one operation and check the literal expectation one cycle later.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_inv);
        logic [W:0] mr;
        @(negedge clk);
        in_valid = 1'b1; alu_op_select = op; opd1 = a; opd2 = b;
        mr = model_op(op, a, b);
        check({name, "_model"}, 32'(mr), 32'({exp_inv, exp_res}));
        @(posedge clk); #1;
        check({name, "_res"}, 32'(shifter_result), 32'(exp_res));
        check({name, "_val"}, 32'(out_valid),      32'd1);
        check({name, "_inv"}, 32'(op_invalid),     32'(exp_inv));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opd1 = '0; opd2 = '0; alu_op_select = 4'd0;
        #2 cmp_en = 1'b1;
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            opd1 = 8'($urandom); opd2 = 8'($urandom);
            alu_op_select = 4'($urandom);
            @(posedge clk); #1;
            check("rst_res", 32'(shifter_result), 32'h00);
            check("rst_val", 32'(out_valid), 32'd0);
            check("rst_inv", 32'(op_invalid), 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;

        do_op("first_inv",  4'b0000, 8'h00, 8'h00, 8'h00, 1'b1);
        do_op("sll3",       4'b0011, 8'h0F, 8'h03, 8'h78, 1'b0);
        do_op("srl3",       4'b0001, 8'hF0, 8'h03, 8'h1E, 1'b0);
        do_op("sra3",       4'b0111, 8'hE0, 8'h03, 8'hFC, 1'b0);
        do_op("sll0",       4'b0011, 8'h0F, 8'h00, 8'h0F, 1'b0);
        do_op("srl0",       4'b0001, 8'hF0, 8'h00, 8'hF0, 1'b0);
        do_op("sra0",       4'b0111, 8'hE0, 8'h00, 8'hE0, 1'b0);
        do_op("sll_mask",   4'b0011, 8'h0F, 8'h0B, 8'h78, 1'b0);
        do_op("sra7",       4'b0111, 8'h80, 8'h07, 8'hFF, 1'b0);
        do_op("srl7",       4'b0001, 8'h80, 8'h07, 8'h01, 1'b0);
        do_op("sra_pos",    4'b0111, 8'h40, 8'h02, 8'h10, 1'b0);
        do_op("sll7",       4'b0011, 8'h81, 8'h07, 8'h80, 1'b0);
        do_op("bad_op",     4'b0101, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op("bad_op2",    4'b0010, 8'hAA, 8'h02, 8'h00, 1'b1);

        // Bubble
        @(negedge clk); in_valid = 1'b0; opd1 = 8'hFF; opd2 = 8'h01; alu_op_select = 4'b0011;
        @(posedge clk); #1;
        check("bubble_res", 32'(shifter_result), 32'h00);
        check("bubble_val", 32'(out_valid), 32'd0);
        check("bubble_inv", 32'(op_invalid), 32'd0);

        // Mid-stream async reset between edges
        do_op("pre_rst", 4'b0001, 8'hF0, 8'h01, 8'h78, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_res", 32'(shifter_result), 32'h00);
        check("async_val", 32'(out_valid), 32'd0);
        check("async_inv", 32'(op_invalid), 32'd0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;

        do_op("post_rst", 4'b0111, 8'h90, 8'h04, 8'hF9, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
